uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Serial transmitter for the team's UART-style single-wire link. It is the driving end of the line that our registered D-flop capture stages sample.
- Accepts a parallel byte through a valid/ready handshake.
- Emits a framed, LSB-first serial bit stream (start, data, optional parity, stop) on a registered output.
- Sits between the host-side byte producer and the FPGA pin.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: payload bits per frame; legal 5..8.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge triggered.
- reset_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a byte to send.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_ready  output  1  transmitter can accept a byte.
- tx_out  output  1  serial line; idle-high, registered.
- tx_busy  output  1  a frame is in progress.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n=0:
  - state=IDLE, tx_out=1, tx_ready=0, tx_busy=0;
  - bit counter, cycle counter and shift register are all 0.
- First cycle after reset release: tx_ready=1.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY_EN=0.
- Handshake: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into the shift register at that edge; later changes to tx_data are ignored.
  - tx_valid while not ready is held off, with no loss and no side effect.
- Latency: tx_out goes 0 on the edge of the handshake and is visible in the following cycle. The FSM enters START.
- Bit timing: each state holds tx_out for exactly CLKS_PER_BIT cycles. The cycle counter counts 0..CLKS_PER_BIT-1; the state advances on terminal count.
- START: tx_out=0.
- DATA: tx_out=shift[0]; shift right each bit period. Runs for DATA_BITS periods (bit index 0..DATA_BITS-1). Leaves to PARITY or STOP.
- PARITY: tx_out = XOR of the latched data bits (even parity).
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- IDLE: tx_out=1.
  - Back-to-back: tx_ready=1 in the first IDLE cycle.
  - So the minimum inter-frame line-high time is (STOP_BITS*CLKS_PER_BIT)+1 cycles.
- tx_busy=1 in START, DATA, PARITY and STOP; tx_busy=0 in IDLE.
- Frame length in cycles: (1 + DATA_BITS + PARITY_EN + STOP_BITS)*CLKS_PER_BIT.
- Reset mid-frame: tx_out returns to 1 asynchronously and the frame is abandoned. No partial frame resumes after release.
- Counter widths: cycle counter is $clog2(CLKS_PER_BIT) bits and never wraps past CLKS_PER_BIT-1. Bit counter is 3 bits.
- tx_out is driven directly from a flop, with no combinational path from inputs.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - line-level constants LINE_IDLE=1 and START_LVL=0;
  - parameter legality checks.
- One sub-module: uart_baud_tick.
  - A cycle counter producing a one-cycle bit_done pulse at CLKS_PER_BIT-1.
  - Cleared when the FSM restarts a frame.
- The FSM and shift register live in the top.

Test Plan:
- Reset hold then release, tx_valid=0 -> tx_out=1, tx_busy=0, tx_ready=1 from the first post-release cycle; line stays high for 100 cycles.
- CLKS_PER_BIT=4, PARITY_EN=0, send 0xA5 -> tx_out, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1. Total 40 cycles; tx_ready low for exactly those 40 cycles.
- PARITY_EN=1, send 0xA5 then 0x01 -> parity bit 0 for 0xA5 and parity bit 1 for 0x01; frame 44 cycles each.
- Back-to-back, tx_valid held high with 0x3C then 0xC3 -> second start bit begins exactly 1 IDLE cycle after the first frame's stop period. tx_data changed mid-frame does not alter the first frame.
- reset_n pulsed low during DATA bit 3 -> tx_out=1 within the same cycle (async). After release: IDLE, tx_ready=1, and no residual bits are sent.
- STOP_BITS=2, CLKS_PER_BIT=2, send 0x00 -> 2 cycles low for start, 16 cycles low for data, 4 cycles high for stop; tx_busy=1 for exactly 22 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_e  : frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   LINE_IDLE     : level of the serial line when nothing is being sent
//   START_LVL     : level of the start bit
//   params_legal  : elaboration-time check of the serializer parameter set
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // True when every parameter is inside the range the serializer supports.
  function automatic bit params_legal(int clks_per_bit, int data_bits,
                                      int parity_en, int stop_bits);
    return (clks_per_bit >= 2) && (clks_per_bit <= 65535) &&
           (data_bits >= 5) && (data_bits <= 8) &&
           (parity_en == 0 || parity_en == 1) &&
           (stop_bits == 1 || stop_bits == 2);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Counts clk cycles 0..CLKS_PER_BIT-1 while enabled and pulses bit_done
// for one cycle on the terminal count, then restarts from 0.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   clear    : restart the bit period from 0 (new frame accepted)
//   enable   : count only while a frame is in progress
//   bit_done : one-cycle pulse in the last cycle of each bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter is held at 0 outside a frame so that every frame starts
  // with a full-length start bit; it wraps itself on terminal count and
  // therefore never exceeds CLKS_PER_BIT-1.
  always_comb begin
    cnt_d    = cnt_q;
    bit_done = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      bit_done = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART-style frame transmitter: accepts a byte over a valid/ready handshake
// and shifts it out LSB first as start, data, optional even parity and
// stop bits on a registered, idle-high serial line.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   tx_valid : producer has a byte to send
//   tx_data  : byte to send, captured only on the handshake edge
//   tx_ready : transmitter can accept a byte (IDLE only)
//   tx_out   : serial line, driven straight from a flop
//   tx_busy  : a frame is in progress
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy
);

  if (!params_legal(CLKS_PER_BIT, DATA_BITS, PARITY_EN, STOP_BITS)) begin : g_param_check
    $error("uart_tx_serializer: illegal parameter combination");
  end

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 ready_q, ready_d;
  logic                 accept;
  logic                 bit_done;

  assign accept = tx_valid && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .enable   (state_q != IDLE),
    .bit_done (bit_done)
  );

  // Next-state logic. The bit counter indexes data bits in DATA and is
  // reused to count stop bits in STOP, so it is cleared on leaving each.
  // Parity is taken from tx_data at the handshake because the shift
  // register no longer holds the whole byte when the parity bit goes out.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = ^tx_data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d = STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and ready are computed from the next state so that the
  // registered outputs change on the same edge as the state itself; this
  // makes the start bit appear in the cycle right after the handshake.
  always_comb begin
    tx_out_d = LINE_IDLE;
    case (state_d)
      START:   tx_out_d = START_LVL;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = LINE_IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= LINE_IDLE;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer. Three instances share clk and
// reset_n: dut_a (4 clk/bit, no parity, 1 stop), dut_p (4 clk/bit, even
// parity, 1 stop) and dut_s (2 clk/bit, no parity, 2 stop).
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;

  logic       va = 1'b0, vp = 1'b0, vs = 1'b0;
  logic [7:0] da = 8'h00, dp = 8'h00, ds = 8'h00;
  logic       ready_a, out_a, busy_a;
  logic       ready_p, out_p, busy_p;
  logic       ready_s, out_s, busy_s;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_valid(va), .tx_data(da),
    .tx_ready(ready_a), .tx_out(out_a), .tx_busy(busy_a)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dut_p (
    .clk(clk), .reset_n(reset_n), .tx_valid(vp), .tx_data(dp),
    .tx_ready(ready_p), .tx_out(out_p), .tx_busy(busy_p)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .tx_valid(vs), .tx_data(ds),
    .tx_ready(ready_s), .tx_out(out_s), .tx_busy(busy_s)
  );

  // Reset values while held, ready on the first cycle after release, and
  // a quiet high line for 100 cycles with no request.
  task automatic test_reset();
    int lows = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tx_out got %b want 1", out_a); end
    tests_run++;
    if (ready_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_ready got %b want 0", ready_a); end
    tests_run++;
    if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tx_busy got %b want 0", busy_a); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_ready got %b want 1", ready_a); end
    tests_run++;
    if (ready_p !== 1'b1 || ready_s !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL release_ready_others got %b%b want 11", ready_p, ready_s);
    end
    tests_run++;
    if (busy_a !== 1'b0 || out_a !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL release_idle busy/out got %b/%b want 0/1", busy_a, out_a);
    end
    repeat (100) begin
      @(negedge clk);
      if (out_a !== 1'b1) lows++;
    end
    tests_run++;
    if (lows != 0) begin tests_failed++; $display("[TB] FAIL idle_line_low_cycles got %0d want 0", lows); end
  endtask

  // One 0xA5 frame at 4 clk/bit: bits 0 | 1,0,1,0,0,1,0,1 | 1, 40 cycles.
  task automatic test_basic_frame();
    logic [11:0] got = '0;
    logic [11:0] exp_bits;
    int busy_cnt = 0, nready_cnt = 0, unstable = 0;
    exp_bits = 12'b00_1_1010_0101_0;
    @(negedge clk);
    va = 1'b1; da = 8'hA5;
    @(posedge clk);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 0) begin va = 1'b0; da = 8'h00; end
      if (k < 40) begin
        if (k % 4 == 0) got[k/4] = out_a;
        else if (out_a !== got[k/4]) unstable++;
      end else if (out_a !== 1'b1) unstable++;
      if (busy_a === 1'b1) busy_cnt++;
      if (ready_a !== 1'b1) nready_cnt++;
    end
    tests_run++;
    if (got !== exp_bits) begin tests_failed++; $display("[TB] FAIL a5_frame_bits got %b want %b", got, exp_bits); end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("[TB] FAIL a5_bit_timing unstable cycles got %0d want 0", unstable); end
    tests_run++;
    if (busy_cnt != 40) begin tests_failed++; $display("[TB] FAIL a5_busy_cycles got %0d want 40", busy_cnt); end
    tests_run++;
    if (nready_cnt != 40) begin tests_failed++; $display("[TB] FAIL a5_not_ready_cycles got %0d want 40", nready_cnt); end
  endtask

  // Even parity: 0xA5 has four ones (parity 0), 0x01 has one (parity 1).
  task automatic test_parity();
    logic [11:0] got;
    logic [11:0] exp_bits;
    int busy_cnt, unstable;
    for (int f = 0; f < 2; f++) begin
      got = '0; busy_cnt = 0; unstable = 0;
      if (f == 0) exp_bits = 12'b0_1_0_1010_0101_0;
      else        exp_bits = 12'b0_1_1_0000_0001_0;
      @(negedge clk);
      vp = 1'b1;
      dp = (f == 0) ? 8'hA5 : 8'h01;
      @(posedge clk);
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (k == 0) vp = 1'b0;
        if (k < 44) begin
          if (k % 4 == 0) got[k/4] = out_p;
          else if (out_p !== got[k/4]) unstable++;
        end else if (out_p !== 1'b1) unstable++;
        if (busy_p === 1'b1) busy_cnt++;
      end
      tests_run++;
      if (got[9] !== exp_bits[9]) begin
        tests_failed++; $display("[TB] FAIL parity_bit frame %0d got %b want %b", f, got[9], exp_bits[9]);
      end
      tests_run++;
      if (got !== exp_bits) begin
        tests_failed++; $display("[TB] FAIL parity_frame_bits frame %0d got %b want %b", f, got, exp_bits);
      end
      tests_run++;
      if (unstable != 0) begin
        tests_failed++; $display("[TB] FAIL parity_bit_timing frame %0d got %0d want 0", f, unstable);
      end
      tests_run++;
      if (busy_cnt != 44) begin
        tests_failed++; $display("[TB] FAIL parity_busy_cycles frame %0d got %0d want 44", f, busy_cnt);
      end
    end
  endtask

  // tx_valid held high: 0x3C then 0xC3 (data changed right after the first
  // handshake). One idle cycle separates the stop period from the next start.
  task automatic test_back_to_back();
    logic [11:0] got1 = '0, got2 = '0;
    logic [11:0] exp1, exp2;
    logic idle_out = 1'b0, idle_rdy = 1'b0;
    int unstable = 0;
    exp1 = 12'b00_1_0011_1100_0;
    exp2 = 12'b00_1_1100_0011_0;
    @(negedge clk);
    va = 1'b1; da = 8'h3C;
    @(posedge clk);
    for (int k = 0; k < 86; k++) begin
      @(negedge clk);
      if (k == 0) da = 8'hC3;
      if (k == 41) va = 1'b0;
      if (k < 40) begin
        if (k % 4 == 0) got1[k/4] = out_a;
        else if (out_a !== got1[k/4]) unstable++;
      end else if (k == 40) begin
        idle_out = out_a; idle_rdy = ready_a;
      end else if (k < 81) begin
        if ((k - 41) % 4 == 0) got2[(k-41)/4] = out_a;
        else if (out_a !== got2[(k-41)/4]) unstable++;
      end else if (out_a !== 1'b1) unstable++;
    end
    tests_run++;
    if (got1 !== exp1) begin tests_failed++; $display("[TB] FAIL b2b_first_frame got %b want %b", got1, exp1); end
    tests_run++;
    if (idle_out !== 1'b1 || idle_rdy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL b2b_idle_gap out/ready got %b/%b want 1/1", idle_out, idle_rdy);
    end
    tests_run++;
    if (got2 !== exp2) begin tests_failed++; $display("[TB] FAIL b2b_second_frame got %b want %b", got2, exp2); end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("[TB] FAIL b2b_bit_timing got %0d want 0", unstable); end
  endtask

  // Reset pulsed during data bit 3 (cycles 16..19) of 0x37, whose bit 3 is 0.
  task automatic test_reset_mid_frame();
    int lows = 0, busy_cnt = 0;
    @(negedge clk);
    va = 1'b1; da = 8'h37;
    @(posedge clk);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) va = 1'b0;
    end
    tests_run++;
    if (out_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_frame_bit3 got %b want 0", out_a); end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_reset_out got %b want 1", out_a); end
    tests_run++;
    if (busy_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_busy got %b want 0", busy_a); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_ready got %b want 1", ready_a); end
    repeat (60) begin
      @(negedge clk);
      if (out_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busy_cnt++;
    end
    tests_run++;
    if (lows != 0) begin tests_failed++; $display("[TB] FAIL residual_bits low cycles got %0d want 0", lows); end
    tests_run++;
    if (busy_cnt != 0) begin tests_failed++; $display("[TB] FAIL residual_busy cycles got %0d want 0", busy_cnt); end
  endtask

  // Two stop bits at 2 clk/bit, 0x00: 2 low start, 16 low data, 4 high stop.
  task automatic test_two_stop_bits();
    logic [11:0] got = '0;
    logic [11:0] exp_bits;
    int lows = 0, highs = 0, busy_cnt = 0, unstable = 0;
    exp_bits = 12'b0_11_0000_0000_0;
    @(negedge clk);
    vs = 1'b1; ds = 8'h00;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) vs = 1'b0;
      if (k < 22) begin
        if (k % 2 == 0) got[k/2] = out_s;
        else if (out_s !== got[k/2]) unstable++;
        if (out_s === 1'b0) lows++;
        if (out_s === 1'b1) highs++;
      end else if (out_s !== 1'b1) unstable++;
      if (busy_s === 1'b1) busy_cnt++;
    end
    tests_run++;
    if (got !== exp_bits) begin tests_failed++; $display("[TB] FAIL stop2_frame_bits got %b want %b", got, exp_bits); end
    tests_run++;
    if (lows != 18) begin tests_failed++; $display("[TB] FAIL stop2_low_cycles got %0d want 18", lows); end
    tests_run++;
    if (highs != 4) begin tests_failed++; $display("[TB] FAIL stop2_high_cycles got %0d want 4", highs); end
    tests_run++;
    if (busy_cnt != 22) begin tests_failed++; $display("[TB] FAIL stop2_busy_cycles got %0d want 22", busy_cnt); end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("[TB] FAIL stop2_bit_timing got %0d want 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop_bits();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
